// File: rtl/sub_pixel_pkg.sv
// rtl/sub_pixel_pkg.sv - shared pixel/row constants for the sub-pixel interpolation path
// Purpose: geometry of the reference block; the interpolator uses the same constants.
// Ports: none (package).
package sub_pixel_pkg;
  localparam int PIX_W = 8;             // bits per pixel
  localparam int BLK   = 15;            // rows per block and pixels per row
  localparam int IDX_W = 4;             // row/column index width, 2**IDX_W > BLK
  localparam int ROW_W = PIX_W * BLK;   // packed row width (120)

  // Index-width forms of the block bounds, so index compares stay width-matched.
  localparam logic [IDX_W-1:0] BLK_IDX  = IDX_W'(BLK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK - 1);
endpackage

// File: rtl/row_bank.sv
// rtl/row_bank.sv - BLK x ROW_W row store with byte write port and row read port
// Purpose: holds one reference block; written one pixel at a time, read one row at a time.
// Ports:
//   clk      in   clock
//   we       in   pixel write enable
//   wr_row   in   row being written
//   wr_col   in   column being written (col0 lands in the row's MSB byte)
//   wr_data  in   pixel value
//   rd_row   in   row to read (combinational); out-of-range rows read as 0
//   rd_data  out  packed row
module row_bank
  import sub_pixel_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_row,
  input  logic [IDX_W-1:0] wr_col,
  input  logic [PIX_W-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_row,
  output logic [ROW_W-1:0] rd_data
);

  // Contents are intentionally not reset; the full flags in the top level
  // decide whether a bank holds meaningful data.
  logic [ROW_W-1:0] mem [BLK];

  always_ff @(posedge clk) begin
    if (we && (wr_row < BLK_IDX) && (wr_col < BLK_IDX)) begin
      mem[wr_row][ROW_W-1-PIX_W*wr_col -: PIX_W] <= wr_data;
    end
  end

  assign rd_data = (rd_row < BLK_IDX) ? mem[rd_row] : '0;

endmodule

// File: rtl/ref_block_row_server.sv
// rtl/ref_block_row_server.sv - ping-pong reference block store serving packed rows
// Purpose: accepts a 15x15 pixel block as a raster byte stream into one of two
//   banks and returns the row selected by next_row, one cycle later, from the
//   bank currently offered to the interpolator.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   s_valid/s_ready/s_data/s_last   pixel stream in (s_last on pixel 225)
//   blk_valid  read bank holds a complete block
//   blk_done   consumer pulse releasing the read bank
//   next_row   requested row index
//   in_row     registered packed row (col0 in MSB byte)
//   row_err    pulse: out-of-range next_row while blk_valid
//   load_err   pulse: s_last framing violation
module ref_block_row_server
  import sub_pixel_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_last,
  output logic             blk_valid,
  input  logic             blk_done,
  input  logic [IDX_W-1:0] next_row,
  output logic [ROW_W-1:0] in_row,
  output logic             row_err,
  output logic             load_err
);

  logic             wb;
  logic             rb;
  logic [1:0]       full;
  logic [1:0]       full_next;
  logic [IDX_W-1:0] col;
  logic [IDX_W-1:0] row;

  logic             accept;
  logic             last_pix;
  logic             commit;
  logic             rel;

  logic [ROW_W-1:0] rd_data0;
  logic [ROW_W-1:0] rd_data1;
  logic [ROW_W-1:0] rd_sel;

  assign s_ready   = ~full[wb];
  assign blk_valid = full[rb];

  assign accept   = s_valid & s_ready;
  assign last_pix = (row == LAST_IDX) && (col == LAST_IDX);
  assign commit   = accept & last_pix;
  assign rel      = blk_done & blk_valid;

  // Commit and release can land in the same cycle; they never address the
  // same bank (commit needs full[wb]=0, release needs full[rb]=1).
  always_comb begin
    full_next = full;
    if (commit) full_next[wb] = 1'b1;
    if (rel)    full_next[rb] = 1'b0;
  end

  row_bank u_bank0 (
    .clk     (clk),
    .we      (accept & ~wb),
    .wr_row  (row),
    .wr_col  (col),
    .wr_data (s_data),
    .rd_row  (next_row),
    .rd_data (rd_data0)
  );

  row_bank u_bank1 (
    .clk     (clk),
    .we      (accept & wb),
    .wr_row  (row),
    .wr_col  (col),
    .wr_data (s_data),
    .rd_row  (next_row),
    .rd_data (rd_data1)
  );

  assign rd_sel = rb ? rd_data1 : rd_data0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb       <= 1'b0;
      rb       <= 1'b0;
      full     <= 2'b00;
      col      <= '0;
      row      <= '0;
      in_row   <= '0;
      row_err  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      row_err  <= 1'b0;
      load_err <= 1'b0;

      if (accept) begin
        if (last_pix) begin
          // Block commits even without s_last; the missing marker is flagged.
          col      <= '0;
          row      <= '0;
          wb       <= ~wb;
          load_err <= ~s_last;
        end else if (s_last) begin
          // Early s_last: drop the partial block, restart at pixel 0 of the same bank.
          col      <= '0;
          row      <= '0;
          load_err <= 1'b1;
        end else if (col == LAST_IDX) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      full <= full_next;
      if (rel) rb <= ~rb;

      // in_row holds its value whenever no complete block is offered.
      if (blk_valid) begin
        if (next_row < BLK_IDX) begin
          in_row <= rd_sel;
        end else begin
          in_row  <= '0;
          row_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ref_block_row_server.sv
// tb/tb_ref_block_row_server.sv - scoreboard bench for ref_block_row_server
module tb_ref_block_row_server;
  import sub_pixel_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] s_data;
  logic             s_last;
  logic             blk_valid;
  logic             blk_done;
  logic [IDX_W-1:0] next_row;
  logic [ROW_W-1:0] in_row;
  logic             row_err;
  logic             load_err;

  ref_block_row_server dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .blk_valid (blk_valid),
    .blk_done  (blk_done),
    .next_row  (next_row),
    .in_row    (in_row),
    .row_err   (row_err),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ROW_W-1:0] rowv;
    logic             err;
    string            name;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  int      lerr_q[$];
  int      n_chk  = 0;
  int      n_pass = 0;
  logic    rd_req = 1'b0;
  logic    req_d  = 1'b0;

  task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected row r of a block whose pixel k is (k + off) mod 256.
  function automatic logic [ROW_W-1:0] exp_row(input int off, input int r);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int c = 0; c < BLK; c++) v[ROW_W-1-PIX_W*c -: PIX_W] = PIX_W'((BLK*r + c + off) % 256);
    return v;
  endfunction

  // Monitor: a read issued before edge N is visible on in_row/row_err after edge N.
  always @(posedge clk) req_d <= rd_req;

  always @(negedge clk) begin
    if (req_d) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 1, 0);
      end else begin
        rd_exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_in_row"}, in_row, e.rowv);
        chk({e.name, "_row_err"}, {119'd0, row_err}, {119'd0, e.err});
      end
    end else if (row_err) begin
      chk("row_err_spurious", {119'd0, row_err}, '0);
    end
    if (load_err) begin
      if (lerr_q.size() == 0) chk("load_err_spurious", {119'd0, load_err}, '0);
      else begin
        void'(lerr_q.pop_front());
        chk("load_err_pulse", {119'd0, load_err}, 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_row(input int idx, input logic [ROW_W-1:0] rv, input logic err, input string name);
    rd_exp_t e;
    e.rowv = rv;
    e.err  = err;
    e.name = name;
    exp_q.push_back(e);
    next_row = IDX_W'(idx);
    rd_req   = 1'b1;
    tick();
    rd_req   = 1'b0;
  endtask

  task automatic pulse_done();
    blk_done = 1'b1;
    tick();
    blk_done = 1'b0;
  endtask

  // Sends n pixels (k+off) mod 256; s_last on pixel last_at (1-based, 0 = never).
  task automatic send_block(input int off, input int n, input int last_at, input bit done_on_last);
    for (int i = 0; i < n; i++) begin
      int tries;
      s_valid = 1'b1;
      s_data  = PIX_W'((i + off) % 256);
      s_last  = (i + 1 == last_at);
      if (done_on_last && i == n - 1) blk_done = 1'b1;
      tries = 0;
      while (!s_ready && tries < 50) begin
        tick();
        tries++;
      end
      if (!s_ready) begin
        chk("s_ready_timeout", {119'd0, s_ready}, 1);
        break;
      end
      tick();
      blk_done = 1'b0;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    chk(name, {119'd0, act}, {119'd0, exp});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; blk_done = 1'b0; next_row = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_bit("rst_s_ready", s_ready, 1'b1);
    chk_bit("rst_blk_valid", blk_valid, 1'b0);
    chk("rst_in_row", in_row, '0);
    chk_bit("rst_row_err", row_err, 1'b0);
    chk_bit("rst_load_err", load_err, 1'b0);

    // T1: single block, rows 0/14 against hand-written values
    send_block(0, 225, 225, 0);
    chk_bit("t1_blk_valid", blk_valid, 1'b1);
    req_row(0, 120'h000102030405060708090A0B0C0D0E, 1'b0, "t1_row0");
    req_row(14, 120'hD2D3D4D5D6D7D8D9DADBDCDDDEDFE0, 1'b0, "t1_row14");
    req_row(7, exp_row(0, 7), 1'b0, "t1_row7");
    // T4: out-of-range row then row 3
    req_row(15, '0, 1'b1, "t4_row15");
    req_row(3, 120'h2D2E2F303132333435363738393A3B, 1'b0, "t4_row3");
    pulse_done();
    chk_bit("t1_released", blk_valid, 1'b0);

    // T2: three blocks, second fills the spare bank, third stalls
    send_block(8'h40, 225, 225, 0);
    send_block(8'h80, 225, 225, 0);
    chk_bit("t2_s_ready_full", s_ready, 1'b0);
    chk_bit("t2_blk_valid", blk_valid, 1'b1);
    req_row(0, exp_row(8'h40, 0), 1'b0, "t2_blk1_row0");
    s_valid = 1'b1; s_data = 8'hC0;
    tick(); tick(); tick();
    chk_bit("t2_stall", s_ready, 1'b0);
    s_valid = 1'b0;
    pulse_done();
    chk_bit("t2_valid_after_done", blk_valid, 1'b1);
    chk_bit("t2_s_ready_after_done", s_ready, 1'b1);
    req_row(0, exp_row(8'h80, 0), 1'b0, "t2_blk2_row0");
    send_block(8'hC0, 225, 225, 0);
    chk_bit("t2_both_full", s_ready, 1'b0);
    pulse_done();
    req_row(0, exp_row(8'hC0, 0), 1'b0, "t2_blk3_row0");
    req_row(14, exp_row(8'hC0, 14), 1'b0, "t2_blk3_row14");
    pulse_done();
    chk_bit("t2_empty", blk_valid, 1'b0);

    // T3: early s_last on pixel 100, then a clean block
    lerr_q.push_back(1);
    send_block(0, 100, 100, 0);
    tick();
    chk_bit("t3_no_commit", blk_valid, 1'b0);
    send_block(0, 225, 225, 0);
    chk_bit("t3_commit", blk_valid, 1'b1);
    req_row(0, 120'h000102030405060708090A0B0C0D0E, 1'b0, "t3_row0");
    req_row(14, 120'hD2D3D4D5D6D7D8D9DADBDCDDDEDFE0, 1'b0, "t3_row14");

    // T6: release bank 0 in the cycle bank 1 commits
    send_block(8'h33, 225, 225, 1);
    chk_bit("t6_blk_valid", blk_valid, 1'b1);
    req_row(5, exp_row(8'h33, 5), 1'b0, "t6_bank1_row5");
    pulse_done();
    chk_bit("t6_empty", blk_valid, 1'b0);

    // T5: reset mid-load, then a load missing s_last on pixel 225
    send_block(8'h77, 50, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk_bit("t5_s_ready", s_ready, 1'b1);
    chk_bit("t5_blk_valid", blk_valid, 1'b0);
    chk("t5_in_row", in_row, '0);
    lerr_q.push_back(1);
    send_block(8'h11, 225, 0, 0);
    chk_bit("t5_commit", blk_valid, 1'b1);
    req_row(2, exp_row(8'h11, 2), 1'b0, "t5_row2");
    tick(); tick();

    chk("exp_q_drained", 120'(exp_q.size()), '0);
    chk("lerr_q_drained", 120'(lerr_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
